// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop sync, tick-driven majority filter, framing FSM, held output word.
// rx_valid rises one clock after the tick that samples the last stop bit; a frame completing while a word is still held is dropped and flagged by overrun.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FILTER_BITS = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 RxD,
    input  logic                 uart_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF      = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL      = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [FILTER_BITS-1:0] filt_cnt_q, filt_cnt_d;
    logic                   filt_q, filt_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   stop_bad_q, stop_bad_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   break_det_q, break_det_d;
    logic                   overrun_q, overrun_d;

    logic frame_done;
    logic fe_now, pe_now, brk_now;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            filt_cnt_q   <= '0;
            filt_q       <= 1'b1;
            baud_q       <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            stop_bad_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            filt_cnt_q   <= filt_cnt_d;
            filt_q       <= filt_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            stop_bad_q   <= stop_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            overrun_q    <= overrun_d;
        end
    end

    // Filtered bit only flips once the counter saturates, so short glitches never reach the FSM.
    always_comb begin
        sync_d     = {sync_q[0], RxD};
        filt_cnt_d = filt_cnt_q;
        filt_d     = filt_q;
        if (uart_tick) begin
            if (!sync_q[1]) begin
                if (filt_cnt_q != '1) filt_cnt_d = filt_cnt_q + FILTER_BITS'(1);
            end else if (filt_cnt_q != '0) begin
                filt_cnt_d = filt_cnt_q - FILTER_BITS'(1);
            end
            if (filt_cnt_d == '1)      filt_d = 1'b0;
            else if (filt_cnt_d == '0) filt_d = 1'b1;
        end
    end

    always_comb begin
        fe_now  = stop_bad_q | ~filt_q;
        pe_now  = (PARITY != 0) && ((^shift_q ^ par_q) != (PARITY == 2));
        brk_now = fe_now && (shift_q == '0) && ((PARITY == 0) || !par_q);
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_bad_d = stop_bad_q;
        frame_done = 1'b0;
        if (uart_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!filt_q) begin
                        state_d = S_START;
                        baud_d  = '0;
                    end
                end
                S_START: begin
                    baud_d = baud_q + CW'(1);
                    if (baud_q == HALF) begin
                        if (filt_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d    = S_DATA;
                            baud_d     = '0;
                            bit_d      = '0;
                            stop_d     = 1'b0;
                            stop_bad_d = 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    baud_d = baud_q + CW'(1);
                    if (baud_q == FULL) begin
                        shift_d = {filt_q, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    baud_d = baud_q + CW'(1);
                    if (baud_q == FULL) begin
                        par_d   = filt_q;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    baud_d = baud_q + CW'(1);
                    if (baud_q == FULL) begin
                        stop_bad_d = fe_now;
                        stop_d     = stop_q + 1'b1;
                        if (stop_q == LAST_STOP) begin
                            frame_done = 1'b1;
                            // A low stop may be a held break; wait for the line to recover first.
                            state_d    = fe_now ? S_WAIT_HIGH : S_IDLE;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (filt_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;
        overrun_d    = 1'b0;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                parity_err_d = pe_now;
                frame_err_d  = fe_now;
                break_det_d  = brk_now;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 7E1, 8N2) driven with directed and random frames.
// Accepted words are collected by handshake monitors and compared against a frame-level model.
module tb_uart_rx_param;

    localparam int OS        = 16;
    localparam int TICK_DIV  = 4;
    localparam int BIT_CLKS  = OS * TICK_DIV;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic uart_tick = 1'b0;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [7:0] data_c;
    logic valid_a, pe_a, fe_a, brk_a, ovr_a;
    logic valid_b, pe_b, fe_b, brk_b, ovr_b;
    logic valid_c, pe_c, fe_c, brk_c, ovr_c;

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS), .FILTER_BITS(2)) dut_a (
        .clock(clock), .reset(reset), .RxD(rxd_a), .uart_tick(uart_tick),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
        .parity_err(pe_a), .frame_err(fe_a), .break_det(brk_a), .overrun(ovr_a));

    uart_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(OS), .FILTER_BITS(2)) dut_b (
        .clock(clock), .reset(reset), .RxD(rxd_b), .uart_tick(uart_tick),
        .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
        .parity_err(pe_b), .frame_err(fe_b), .break_det(brk_b), .overrun(ovr_b));

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(OS), .FILTER_BITS(2)) dut_c (
        .clock(clock), .reset(reset), .RxD(rxd_c), .uart_tick(uart_tick),
        .rx_data(data_c), .rx_valid(valid_c), .rx_ready(ready_c),
        .parity_err(pe_c), .frame_err(fe_c), .break_det(brk_c), .overrun(ovr_c));

    always #5 clock = ~clock;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(posedge clock);
            #1 uart_tick = 1'b1;
            @(posedge clock);
            #1 uart_tick = 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Word record: {dut id, break, frame, parity, data[8:0]}
    logic [13:0] got_q[$];
    logic [13:0] exp_q[$];
    int ovr_cnt_a = 0;
    int ovr_cyc_a = 0;
    int ovr_other = 0;

    always @(negedge clock) begin
        if (valid_a && ready_a) got_q.push_back({2'd0, brk_a, fe_a, pe_a, 1'b0, data_a});
        if (valid_b && ready_b) got_q.push_back({2'd1, brk_b, fe_b, pe_b, 2'b00, data_b});
        if (valid_c && ready_c) got_q.push_back({2'd2, brk_c, fe_c, pe_c, 1'b0, data_c});
        if (ovr_a) begin
            ovr_cnt_a = ovr_cnt_a + 1;
            ovr_cyc_a = cyc;
        end
        if (ovr_b || ovr_c) ovr_other = ovr_other + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_queue(input string tag);
        int n;
        check_eq({tag, ".words"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s.word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [13:0] model_word(input int sel, input int d, input int pmode,
                                               input bit pbit, input bit stop_bad);
        int  ones;
        bit  pe, brk;
        logic [1:0] id;
        logic [8:0] dv;
        ones = $countones(d);
        pe   = (pmode != 0) && (((ones + int'(pbit)) % 2) != ((pmode == 2) ? 1 : 0));
        brk  = stop_bad && (d == 0) && (pmode == 0 || !pbit);
        id   = sel[1:0];
        dv   = d[8:0];
        return {id, brk, stop_bad, pe, dv};
    endfunction

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic hold_line(input int sel, input logic v, input int nticks);
        set_line(sel, v);
        repeat (nticks * TICK_DIV) @(posedge clock);
        #1;
    endtask

    task automatic align_tick();
        int n = 0;
        do begin
            @(posedge clock);
            n++;
        end while (uart_tick !== 1'b1 && n < 2 * TICK_DIV);
        #1;
    endtask

    int frame_t0 = 0;

    task automatic send_frame(input int sel, input int d, input int nbits, input int pmode,
                              input bit flip_par, input int nstop, input bit stop_bad,
                              input bit expect_it);
        int ones;
        bit pb;
        ones = $countones(d);
        pb   = (pmode == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        pb   = pb ^ flip_par;
        align_tick();
        frame_t0 = cyc;
        hold_line(sel, 1'b0, OS);
        for (int i = 0; i < nbits; i++) hold_line(sel, ((d >> i) & 1) != 0, OS);
        if (pmode != 0) hold_line(sel, pb, OS);
        for (int s = 0; s < nstop; s++) hold_line(sel, !(stop_bad && s == nstop - 1), OS);
        hold_line(sel, 1'b1, 4 * OS);
        if (expect_it) exp_q.push_back(model_word(sel, d, pmode, (pmode != 0) ? pb : 1'b0, stop_bad));
    endtask

    initial begin
        #(1_500_000);
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0_f2, off, d;
        bit bad, flip;

        #3 reset = 1'b0;
        #2;
        check_eq("rst.rx_data",    32'(data_a), 32'h0);
        check_eq("rst.rx_valid",   32'({valid_a, valid_b, valid_c}), 32'h0);
        check_eq("rst.flags",      32'({pe_a, fe_a, brk_a, ovr_a}), 32'h0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (20) @(posedge clock);
        #1;

        // 8N1 clean frame
        send_frame(0, 8'hA5, 8, 0, 1'b0, 1, 1'b0, 1'b1);
        check_queue("a5");

        // 7E1 with wrong parity bit
        send_frame(1, 7'h55, 7, 1, 1'b1, 1, 1'b0, 1'b1);
        check_queue("parity");

        // 8N2: second stop low, then a clean frame
        send_frame(2, 8'h3C, 8, 0, 1'b0, 2, 1'b1, 1'b1);
        send_frame(2, 8'h81, 8, 0, 1'b0, 2, 1'b0, 1'b1);
        check_queue("stop2");

        // Line held low for three frame times
        align_tick();
        hold_line(0, 1'b0, 30 * OS);
        hold_line(0, 1'b1, 4 * OS);
        exp_q.push_back(model_word(0, 0, 0, 1'b0, 1'b1));
        check_queue("break");
        send_frame(0, 8'h5A, 8, 0, 1'b0, 1, 1'b0, 1'b1);
        check_queue("after_break");

        // Glitches on the idle line
        align_tick();
        hold_line(0, 1'b0, 1);
        hold_line(0, 1'b1, 3 * OS);
        check_queue("glitch1");
        hold_line(0, 1'b0, 6);
        hold_line(0, 1'b1, 3 * OS);
        check_queue("false_start");
        send_frame(0, 8'hE7, 8, 0, 1'b0, 1, 1'b0, 1'b1);
        check_queue("after_glitch");

        // Overrun, then a handshake coincident with the third completion
        ready_a = 1'b0;
        send_frame(0, 8'h11, 8, 0, 1'b0, 1, 1'b0, 1'b1);
        t0_f2 = 0;
        send_frame(0, 8'h22, 8, 0, 1'b0, 1, 1'b0, 1'b0);
        t0_f2 = frame_t0;
        check_eq("ovr.count",    ovr_cnt_a, 1);
        check_eq("ovr.held",     32'(data_a), 32'h11);
        check_eq("ovr.valid",    32'(valid_a), 32'h1);
        off = ovr_cyc_a - t0_f2;
        frame_t0 = -1;
        fork
            send_frame(0, 8'h33, 8, 0, 1'b0, 1, 1'b0, 1'b1);
            begin
                wait (frame_t0 >= 0);
                if (off > 1) repeat (off - 1) @(posedge clock);
                #1 ready_a = 1'b1;
                @(posedge clock);
                #1 ready_a = 1'b0;
                @(negedge clock);
                check_eq("coincide.valid", 32'(valid_a), 32'h1);
                check_eq("coincide.data",  32'(data_a),  32'h33);
            end
        join
        check_eq("ovr.count_after", ovr_cnt_a, 1);
        ready_a = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check_queue("overrun");

        // Reset in the middle of the data bits
        ready_a = 1'b0;
        send_frame(0, 8'h7E, 8, 0, 1'b0, 1, 1'b0, 1'b0);
        check_eq("midrst.pre_valid", 32'(valid_a), 32'h1);
        align_tick();
        hold_line(0, 1'b0, OS);
        hold_line(0, 1'b1, OS);
        hold_line(0, 1'b0, OS);
        hold_line(0, 1'b1, OS / 2);
        reset = 1'b0;
        #1;
        check_eq("midrst.rx_data",  32'(data_a),  32'h0);
        check_eq("midrst.rx_valid", 32'(valid_a), 32'h0);
        check_eq("midrst.flags",    32'({pe_a, fe_a, brk_a, ovr_a}), 32'h0);
        set_line(0, 1'b1);
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        ready_a = 1'b1;
        hold_line(0, 1'b1, 2 * OS);
        send_frame(0, 8'hC3, 8, 0, 1'b0, 1, 1'b0, 1'b1);
        check_queue("after_reset");

        // Random 8N1 frames, some with a bad stop bit or all-zero data
        for (int i = 0; i < 12; i++) begin
            d   = $urandom_range(0, 255);
            bad = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) d = 0;
            send_frame(0, d, 8, 0, 1'b0, 1, bad, 1'b1);
        end
        check_queue("rand_a");

        // Random 7E1 frames with random parity corruption
        for (int i = 0; i < 10; i++) begin
            d    = $urandom_range(0, 127);
            flip = ($urandom_range(0, 1) == 1);
            send_frame(1, d, 7, 1, flip, 1, 1'b0, 1'b1);
        end
        check_queue("rand_b");

        check_eq("ovr.total_a",     ovr_cnt_a, 1);
        check_eq("ovr.other_duts",  ovr_other, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
